// File: rtl/uart_tx_unit.sv
// uart_tx_unit: UART serial transmitter fed from the memory dump stage.
// Accepts one word per valid/ready handshake and shifts it out LSB first,
// framed as start bit, data bits, optional even parity, then stop bit(s).
// The line output is registered, so the start bit appears on the edge after
// acceptance. A valid held high across frame end or reset cannot re-trigger
// a send: valid must be seen low at least once before the next acceptance.
module uart_tx_unit #(
    parameter int UART_DATA_SIZE = 8,
    parameter int CLKS_PER_BIT   = 868,
    parameter int PARITY_EN      = 0,
    parameter int STOP_BITS      = 1
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic [UART_DATA_SIZE-1:0] i_data,
    input  logic                      i_valid,
    output logic                      o_ready,
    output logic                      o_tx,
    output logic                      o_done
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(UART_DATA_SIZE + 1);

    localparam logic [CW-1:0] CYC_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(UART_DATA_SIZE - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    logic [2:0]                state;
    logic [CW-1:0]             cycle_cnt;
    logic [BW-1:0]             bit_cnt;
    logic [UART_DATA_SIZE-1:0] shift_reg;
    logic                      parity_bit;
    logic                      armed;
    logic                      accept;
    logic                      bit_end;

    assign accept  = (state == ST_IDLE) && i_valid && armed;
    assign bit_end = (cycle_cnt == CYC_LAST);

    // Arm on any cycle with valid low; disarm when a word is taken.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            armed <= 1'b0;
        end else if (accept) begin
            armed <= 1'b0;
        end else if (!i_valid) begin
            armed <= 1'b1;
        end
    end

    // Frame sequencer: bit timing, shift register and registered line/handshake outputs.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state      <= ST_IDLE;
            cycle_cnt  <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
            o_tx       <= 1'b1;
            o_ready    <= 1'b1;
            o_done     <= 1'b0;
        end else begin
            o_done <= 1'b0;

            if (state == ST_IDLE) begin
                cycle_cnt <= '0;
            end else if (bit_end) begin
                cycle_cnt <= '0;
            end else begin
                cycle_cnt <= cycle_cnt + CW'(1);
            end

            case (state)
                ST_IDLE: begin
                    bit_cnt <= '0;
                    if (accept) begin
                        shift_reg  <= i_data;
                        parity_bit <= ^i_data;
                        state      <= ST_START;
                        o_ready    <= 1'b0;
                        o_tx       <= 1'b0;
                    end
                end

                ST_START: begin
                    if (bit_end) begin
                        state     <= ST_DATA;
                        bit_cnt   <= '0;
                        o_tx      <= shift_reg[0];
                        shift_reg <= shift_reg >> 1;
                    end
                end

                ST_DATA: begin
                    if (bit_end) begin
                        if (bit_cnt == DATA_LAST) begin
                            bit_cnt <= '0;
                            if (PARITY_EN != 0) begin
                                state <= ST_PARITY;
                                o_tx  <= parity_bit;
                            end else begin
                                state <= ST_STOP;
                                o_tx  <= 1'b1;
                            end
                        end else begin
                            bit_cnt   <= bit_cnt + BW'(1);
                            o_tx      <= shift_reg[0];
                            shift_reg <= shift_reg >> 1;
                        end
                    end
                end

                ST_PARITY: begin
                    if (bit_end) begin
                        state   <= ST_STOP;
                        bit_cnt <= '0;
                        o_tx    <= 1'b1;
                    end
                end

                ST_STOP: begin
                    if (bit_end) begin
                        if (bit_cnt == STOP_LAST) begin
                            state   <= ST_IDLE;
                            bit_cnt <= '0;
                            o_ready <= 1'b1;
                            o_done  <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + BW'(1);
                        end
                    end
                end

                default: begin
                    state   <= ST_IDLE;
                    bit_cnt <= '0;
                    o_tx    <= 1'b1;
                    o_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_unit.sv
// tb_uart_tx_unit: directed bench for uart_tx_unit with CLKS_PER_BIT=4.
// One instance is 8N1, a second uses even parity with two stop bits.
module tb_uart_tx_unit;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] d0, d1;
    logic       v0, v1;
    logic       r0, r1, tx0, tx1, dn0, dn1;

    always #5 clk = ~clk;

    uart_tx_unit #(
        .UART_DATA_SIZE(8),
        .CLKS_PER_BIT  (CPB),
        .PARITY_EN     (0),
        .STOP_BITS     (1)
    ) dut (
        .i_clock(clk),
        .i_reset(rst),
        .i_data (d0),
        .i_valid(v0),
        .o_ready(r0),
        .o_tx   (tx0),
        .o_done (dn0)
    );

    uart_tx_unit #(
        .UART_DATA_SIZE(8),
        .CLKS_PER_BIT  (CPB),
        .PARITY_EN     (1),
        .STOP_BITS     (2)
    ) dut_p (
        .i_clock(clk),
        .i_reset(rst),
        .i_data (d1),
        .i_valid(v1),
        .o_ready(r1),
        .o_tx   (tx1),
        .o_done (dn1)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [63:0] last_cap;
    int          last_busy;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Send one word to instance sel (0: 8N1, 1: 8E2), holding valid for
    // 'hold' cycles and switching i_data to 'alt' partway through the frame.
    task automatic send_frame(input int sel, input logic [7:0] b, input int hold,
                              input logic [7:0] alt, input string tag);
        int          par, stops, nbits, fl, busy, dcnt;
        logic [15:0] bitv;
        logic [63:0] expw, cap;
        logic        tx, rdy, dn;
        par   = sel;
        stops = (sel == 0) ? 1 : 2;
        nbits = 1 + 8 + par + stops;
        fl    = nbits * CPB;
        bitv  = '1;
        bitv[0] = 1'b0;
        for (int i = 0; i < 8; i++) bitv[1+i] = b[i];
        if (par != 0) bitv[9] = ^b;
        expw = '0;
        cap  = '0;
        for (int c = 0; c < fl; c++) expw[c] = bitv[c/CPB];
        busy = 0;
        dcnt = 0;

        @(negedge clk);
        if (sel == 0) begin d0 = b; v0 = 1'b1; end
        else          begin d1 = b; v1 = 1'b1; end

        for (int c = 0; c < fl; c++) begin
            @(negedge clk);
            tx  = (sel == 0) ? tx0 : tx1;
            rdy = (sel == 0) ? r0  : r1;
            dn  = (sel == 0) ? dn0 : dn1;
            cap[c] = tx;
            if (!rdy) busy++;
            if (dn) dcnt++;
            if (c == hold - 1) begin
                if (sel == 0) v0 = 1'b0; else v1 = 1'b0;
            end
            if (c == 10) begin
                if (sel == 0) d0 = alt; else d1 = alt;
            end
        end
        last_cap  = cap;
        last_busy = busy;
        check_eq({tag, "_line"}, cap, expw);
        check_eq({tag, "_busy"}, 64'(busy), 64'(fl));
        check_eq({tag, "_done_early"}, 64'(dcnt), 64'd0);

        @(negedge clk);
        check_eq({tag, "_done"},  64'((sel == 0) ? dn0 : dn1), 64'd1);
        check_eq({tag, "_ready"}, 64'((sel == 0) ? r0  : r1),  64'd1);
        check_eq({tag, "_idle"},  64'((sel == 0) ? tx0 : tx1), 64'd1);
        @(negedge clk);
        check_eq({tag, "_done_off"}, 64'((sel == 0) ? dn0 : dn1), 64'd0);
    endtask

    // Watch instance 0 for n cycles; returns cycles spent idle (ready=1, line high) and done pulses.
    task automatic watch_idle(input int n, output int idle_cnt, output int done_cnt);
        idle_cnt = 0;
        done_cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (r0 && tx0) idle_cnt++;
            if (dn0) done_cnt++;
        end
    endtask

    initial begin
        int ic, dc;
        rst = 1'b1;
        d0 = 8'h00; d1 = 8'h00;
        v0 = 1'b0;  v1 = 1'b0;

        @(negedge clk);
        check_eq("rst_tx",    64'(tx0), 64'd1);
        check_eq("rst_ready", 64'(r0),  64'd1);
        check_eq("rst_done",  64'(dn0), 64'd0);
        check_eq("rst_p_tx",  64'(tx1), 64'd1);
        rst = 1'b0;

        // Reset asserted during the start bit, with valid still held high.
        @(negedge clk);
        d0 = 8'hC3; v0 = 1'b1;
        @(negedge clk);
        check_eq("mid_start_tx",    64'(tx0), 64'd0);
        check_eq("mid_start_ready", 64'(r0),  64'd0);
        #2 rst = 1'b1;
        #1;
        check_eq("async_rst_tx",    64'(tx0), 64'd1);
        check_eq("async_rst_ready", 64'(r0),  64'd1);
        check_eq("async_rst_done",  64'(dn0), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        watch_idle(8, ic, dc);
        check_eq("post_rst_no_resend", 64'(ic), 64'd8);
        check_eq("post_rst_no_done",   64'(dc), 64'd0);
        v0 = 1'b0;

        // 0xA5, valid held 4 cycles.
        send_frame(0, 8'hA5, 4, 8'hA5, "a5");
        check_eq("a5_exact_line", last_cap[39:0], 64'h00_FF0F00F0F0);
        check_eq("a5_len", 64'(last_busy), 64'd40);

        // Dump-style sequence.
        send_frame(0, 8'h12, 4, 8'h12, "seq12");
        send_frame(0, 8'h34, 4, 8'h34, "seq34");
        send_frame(0, 8'hFF, 4, 8'hFF, "seqFF");
        watch_idle(10, ic, dc);
        check_eq("seq_no_dup", 64'(ic), 64'd10);

        // Valid held high continuously: one frame only until valid drops.
        send_frame(0, 8'h55, 100000, 8'h55, "hold");
        watch_idle(12, ic, dc);
        check_eq("hold_no_repeat",  64'(ic), 64'd12);
        check_eq("hold_no_done",    64'(dc), 64'd0);
        check_eq("hold_valid_high", 64'(v0), 64'd1);
        @(negedge clk);
        v0 = 1'b0;
        send_frame(0, 8'h55, 4, 8'h55, "rearm");

        // Even parity, two stop bits.
        send_frame(1, 8'h07, 4, 8'h07, "par07");
        check_eq("par07_parity_bit", last_cap[39:36], 64'hF);
        check_eq("par07_stop_bits",  last_cap[47:40], 64'hFF);
        check_eq("par07_len", 64'(last_busy), 64'd48);

        // Data change mid-frame has no effect.
        send_frame(0, 8'h0F, 4, 8'hF0, "chg");
        check_eq("chg_exact_line", last_cap[39:0], 64'h00_F0000FFFF0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
